dmg_lcd_capture: RTL and testbench
==================================

# dmg_lcd_capture

Downstream consumer of the PPU LCD stream (`lcd_vsync`, `lcd_hsync`, `lcd_pixel`, `lcd_color`) in the DMG core. It tracks the beam position, packs 2-bpp pixels four to a byte, and writes a 160x144 frame into a 5760-byte framebuffer RAM write port for the video scan-out side. It also reports frame completion and stream-protocol errors.

## Interface
Parameters:
- `H_PIXELS`, 160: active pixels per line; must be a multiple of 4.
- `V_LINES`, 144: active lines per frame.

Ports:
- `clk`  in  1  system clock; same clock as the PPU.
- `rst`  in  1  asynchronous, active-low reset.
- `lcd_vsync`  in  1  frame sync; its rising edge starts a new frame.
- `lcd_hsync`  in  1  line sync; its rising edge ends the current line.
- `lcd_pixel`  in  1  one-cycle strobe; `lcd_color` is valid in that cycle.
- `lcd_color`  in  2  pixel shade, 0 to 3.
- `fb_addr`  out  13  byte address, y*40 + x/4.
- `fb_data`  out  8  packed byte; the first pixel in a byte sits in [7:6], the last in [1:0].
- `fb_write`  out  1  one-cycle write strobe.
- `fb_bank`  out  1  write bank (see Configuration).
- `frame_done`  out  1  one-cycle pulse when a frame completes.
- `err_long`, `err_short`, `err_extra`  out  1 each  sticky error flags.
- `err_clr`  in  1  clears all three sticky flags.

## Operation
- Internal state: x counter (0 to 160), y counter (0 to 144), 2-bit pixel phase, 6-bit shift register, byte-address counter.
- Line address is kept incrementally: add 40 per line. No multiplier.
- State machine:
  - WAIT_FRAME (after reset): waits for a vsync rising edge.
  - ACTIVE: captures pixels.
  - FRAME_END: entered once line 143 ends; ignores pixels and hsync edges until the next vsync edge, then goes to ACTIVE.
- Sync edges are detected against a registered copy of each sync input. An edge is acted on in the first cycle the input is seen high.
- Pixel strobe in ACTIVE with x < 160:
  - shift `lcd_color` into the byte and increment x.
  - On phase 3, drive `fb_data`/`fb_addr` and `fb_write` = 1 on the next cycle.
- Pixel strobe in ACTIVE with x = 160: pixel is dropped, `err_long` is set.
- hsync edge in ACTIVE:
  - If phase != 0, flush the partial byte padded with 0 in the unused low pixels, write it, and set `err_short`.
  - If x < 160 at the edge, also set `err_short`.
  - Then x = 0, phase = 0, y += 1, line base += 40.
  - When y reaches 144: pulse `frame_done` and go to FRAME_END.
- Pixel strobe in FRAME_END or WAIT_FRAME: dropped; `err_extra` is set in FRAME_END only.
- vsync edge in any state: x, y, phase and address return to 0 and the state goes to ACTIVE. A partial line or partial byte is discarded without a write. If this happens before 144 lines, `frame_done` is not pulsed.
- Same-cycle events: the pixel is processed first, then hsync, then vsync. A pixel and a vsync edge in the same cycle means the pixel is pixel 0 of the new frame.
- `err_clr` has priority below a same-cycle error set (the set wins).

## Timing
- Pixel-to-write latency: `fb_write` is high exactly 1 cycle after the 4th strobe of a byte, and after an hsync edge for a flush.
- `fb_addr`/`fb_data` are stable while `fb_write` is high; the RAM samples them on that edge.
- `frame_done` is asserted in the same cycle as the final write of line 143 or later, and never earlier.
- Back-to-back pixel strobes on every cycle are supported.
- Reset values:
  - `fb_write` = 0, `frame_done` = 0, `fb_addr` = 0, `fb_data` = 0, `fb_bank` = 0, all error flags = 0.
  - State = WAIT_FRAME.
- Reset mid-line aborts the line immediately; no write is issued afterwards.

## Configuration
- `DMG_LCD_DBUF_EN` defined:
  - Double-buffered. `fb_bank` selects the half of a 2x5760-byte RAM being written.
  - It toggles on the vsync edge that follows a `frame_done`, so the display reads the `~fb_bank` half.
  - An aborted frame (vsync before 144 lines) does not toggle it.
- `DMG_LCD_DBUF_EN` undefined: single buffer; `fb_bank` is tied to 0.

## Test plan
- Reset, vsync edge, 160 strobes with colors 3,2,1,0 repeating, then hsync -> 40 writes of 0xE4 at addresses 0 to 39, each 1 cycle after its 4th strobe. No error flags.
- Full frame of 144 lines -> last write at 0x167F. `frame_done` pulses once. With `DMG_LCD_DBUF_EN`, `fb_bank` becomes 1 on the next vsync.
- Line of 162 strobes, all color 1 -> 40 writes of 0x55, 2 pixels dropped, `err_long` = 1. `err_clr` returns it to 0.
- Line of 158 strobes, all color 3, then hsync -> byte 39 written as 0xF0 at address 39, `err_short` = 1, next line starts at address 40.
- vsync edge after 50 lines plus 6 pixels -> no flush write, no `frame_done`, next pixel packs into address 0, `fb_bank` unchanged.
- Strobes after line 143 and before vsync -> no writes, `err_extra` = 1. Asynchronous reset mid-byte -> all outputs 0 in the same cycle.

Source files
------------

// File: rtl/dmg_lcd_capture_if.sv
// LCD stream / framebuffer write bundle for dmg_lcd_capture.
// master = stream source and RAM side, slave = the capture block.
interface dmg_lcd_capture_if;
  logic        lcd_vsync;
  logic        lcd_hsync;
  logic        lcd_pixel;
  logic [1:0]  lcd_color;
  logic [12:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_write;
  logic        fb_bank;
  logic        frame_done;
  logic        err_long;
  logic        err_short;
  logic        err_extra;
  logic        err_clr;

  modport master (
    output lcd_vsync, lcd_hsync, lcd_pixel, lcd_color, err_clr,
    input  fb_addr, fb_data, fb_write, fb_bank, frame_done,
    input  err_long, err_short, err_extra
  );

  modport slave (
    input  lcd_vsync, lcd_hsync, lcd_pixel, lcd_color, err_clr,
    output fb_addr, fb_data, fb_write, fb_bank, frame_done,
    output err_long, err_short, err_extra
  );
endinterface

// File: rtl/dmg_lcd_capture.sv
// DMG LCD capture: packs the 2-bpp PPU stream into a 160x144 framebuffer.
// Define DMG_LCD_DBUF_EN for a double-buffered store with a toggling fb_bank.
module dmg_lcd_capture #(
  parameter int H_PIXELS = 160,
  parameter int V_LINES  = 144
) (
  input  logic             clk,
  input  logic             rst,
  dmg_lcd_capture_if.slave bus
);
  localparam int XW = $clog2(H_PIXELS + 1);
  localparam int YW = $clog2(V_LINES + 1);
  localparam logic [XW-1:0] XMAX  = XW'(H_PIXELS);
  localparam logic [YW-1:0] YLAST = YW'(V_LINES - 1);
  localparam logic [12:0]   BPL   = 13'(H_PIXELS / 4);

  typedef enum logic [1:0] {
    WAIT_FRAME,
    ACTIVE,
    FRAME_END
  } state_e;

  state_e      state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [1:0]  ph_q, ph_d;
  logic [5:0]  sh_q, sh_d;
  logic [12:0] base_q, base_d;
  logic [12:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        wr_q, wr_d;
  logic        done_q, done_d;
  logic        vs_q, hs_q;
  logic        long_q, short_q, extra_q;
  logic        set_long, set_short, set_extra;
  logic        vs_edge, hs_edge;

  assign vs_edge = bus.lcd_vsync & ~vs_q;
  assign hs_edge = bus.lcd_hsync & ~hs_q;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    ph_d      = ph_q;
    sh_d      = sh_q;
    base_d    = base_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wr_d      = 1'b0;
    done_d    = 1'b0;
    set_long  = 1'b0;
    set_short = 1'b0;
    set_extra = 1'b0;

    // a pixel beside a vsync edge belongs to the new frame, handled below
    if (bus.lcd_pixel && !vs_edge) begin
      unique case (state_q)
        ACTIVE: begin
          if (x_q < XMAX) begin
            x_d  = x_q + XW'(1);
            ph_d = ph_q + 2'd1;
            sh_d = {sh_q[3:0], bus.lcd_color};
            if (ph_q == 2'd3) begin
              wr_d   = 1'b1;
              addr_d = base_q + 13'(x_q >> 2);
              data_d = {sh_q, bus.lcd_color};
            end
          end else begin
            set_long = 1'b1;
          end
        end
        FRAME_END: set_extra = 1'b1;
        default: ;
      endcase
    end

    if (hs_edge && state_q == ACTIVE) begin
      if (ph_d != 2'd0) begin
        wr_d      = 1'b1;
        addr_d    = base_q + 13'(x_d >> 2);
        set_short = 1'b1;
        unique case (ph_d)
          2'd1:    data_d = {sh_d[1:0], 6'd0};
          2'd2:    data_d = {sh_d[3:0], 4'd0};
          default: data_d = {sh_d, 2'd0};
        endcase
      end
      if (x_d < XMAX) set_short = 1'b1;
      x_d    = '0;
      ph_d   = '0;
      y_d    = y_q + YW'(1);
      base_d = base_q + BPL;
      if (y_q == YLAST) begin
        done_d  = 1'b1;
        state_d = FRAME_END;
      end
    end

    if (vs_edge) begin
      state_d = ACTIVE;
      x_d     = '0;
      y_d     = '0;
      ph_d    = '0;
      base_d  = '0;
      if (bus.lcd_pixel) begin
        x_d  = XW'(1);
        ph_d = 2'd1;
        sh_d = {4'd0, bus.lcd_color};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= WAIT_FRAME;
      x_q     <= '0;
      y_q     <= '0;
      ph_q    <= '0;
      sh_q    <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      vs_q    <= 1'b0;
      hs_q    <= 1'b0;
      long_q  <= 1'b0;
      short_q <= 1'b0;
      extra_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ph_q    <= ph_d;
      sh_q    <= sh_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      vs_q    <= bus.lcd_vsync;
      hs_q    <= bus.lcd_hsync;
      long_q  <= (long_q & ~bus.err_clr) | set_long;
      short_q <= (short_q & ~bus.err_clr) | set_short;
      extra_q <= (extra_q & ~bus.err_clr) | set_extra;
    end
  end

`ifdef DMG_LCD_DBUF_EN
  logic bank_q;
  logic fin_q;

  // flip only on the vsync that follows a completed frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_q <= 1'b0;
      fin_q  <= 1'b0;
    end else if (vs_edge) begin
      bank_q <= bank_q ^ (fin_q | done_d);
      fin_q  <= 1'b0;
    end else if (done_d) begin
      fin_q  <= 1'b1;
    end
  end

  assign bus.fb_bank = bank_q;
`else
  assign bus.fb_bank = 1'b0;
`endif

  assign bus.fb_addr    = addr_q;
  assign bus.fb_data    = data_q;
  assign bus.fb_write   = wr_q;
  assign bus.frame_done = done_q;
  assign bus.err_long   = long_q;
  assign bus.err_short  = short_q;
  assign bus.err_extra  = extra_q;
endmodule

// File: tb/tb_dmg_lcd_capture.sv
// Bench for dmg_lcd_capture: line-buffer model checked every cycle,
// plus literal expectations for the headline cases.
module tb_dmg_lcd_capture;
  localparam int H = 160;
  localparam int V = 144;
`ifdef DMG_LCD_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  dmg_lcd_capture_if bus ();

  dmg_lcd_capture #(
    .H_PIXELS(H),
    .V_LINES (V)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic        done;
    logic        bank;
    logic        el;
    logic        es;
    logic        ex;
    logic [12:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t e, n;
  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;
  int nwr = 0;
  int ndone = 0;
  logic [12:0] first_addr, last_addr;
  logic [7:0]  first_data, last_data;

  // model: 0 waiting, 1 active, 2 frame ended
  int          m_st;
  int          m_y;
  logic [1:0]  lbuf[$];
  bit          m_vs, m_hs, m_fin, m_bank;
  bit          m_long, m_short, m_extra;
  logic [12:0] m_addr;
  logic [7:0]  m_data;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("fb_write", 32'(bus.fb_write), 32'(e.wr));
      chk("fb_addr", 32'(bus.fb_addr), 32'(e.addr));
      chk("fb_data", 32'(bus.fb_data), 32'(e.data));
      chk("frame_done", 32'(bus.frame_done), 32'(e.done));
      chk("fb_bank", 32'(bus.fb_bank), 32'(e.bank));
      chk("err_long", 32'(bus.err_long), 32'(e.el));
      chk("err_short", 32'(bus.err_short), 32'(e.es));
      chk("err_extra", 32'(bus.err_extra), 32'(e.ex));
      if (bus.fb_write === 1'b1) begin
        if (nwr == 0) begin
          first_addr = bus.fb_addr;
          first_data = bus.fb_data;
        end
        last_addr = bus.fb_addr;
        last_data = bus.fb_data;
        nwr++;
      end
      if (bus.frame_done === 1'b1) ndone++;
    end
  end

  task automatic mreset();
    m_st = 0; m_y = 0; lbuf.delete();
    m_vs = 0; m_hs = 0; m_fin = 0; m_bank = 0;
    m_long = 0; m_short = 0; m_extra = 0;
    m_addr = '0; m_data = '0;
    e = '0; n = '0;
  endtask

  // write byte idx of the current line, unused pixels padded with 0
  task automatic emit(input int idx);
    logic [7:0] b;
    b = '0;
    for (int k = 0; k < 4; k++) begin
      if (idx * 4 + k < lbuf.size())
        b = b | (8'(lbuf[idx*4+k]) << (6 - 2 * k));
    end
    n.wr   = 1'b1;
    m_addr = 13'(m_y * (H / 4) + idx);
    m_data = b;
  endtask

  task automatic step(input bit vs, input bit hs, input bit px,
                      input logic [1:0] col, input bit clr);
    bit vse, hse, sl, ss, sx;
    bus.lcd_vsync = vs;
    bus.lcd_hsync = hs;
    bus.lcd_pixel = px;
    bus.lcd_color = col;
    bus.err_clr   = clr;
    vse = vs && !m_vs;
    hse = hs && !m_hs;
    m_vs = vs;
    m_hs = hs;
    sl = 0; ss = 0; sx = 0;
    n.wr = 1'b0;
    n.done = 1'b0;
    if (px && !vse) begin
      if (m_st == 1) begin
        if (lbuf.size() < H) begin
          lbuf.push_back(col);
          if (lbuf.size() % 4 == 0) emit(lbuf.size() / 4 - 1);
        end else begin
          sl = 1;
        end
      end else if (m_st == 2) begin
        sx = 1;
      end
    end
    if (hse && m_st == 1) begin
      if (lbuf.size() % 4 != 0) begin
        emit(lbuf.size() / 4);
        ss = 1;
      end
      if (lbuf.size() < H) ss = 1;
      lbuf.delete();
      m_y++;
      if (m_y == V) begin
        n.done = 1'b1;
        m_st = 2;
        m_fin = 1;
      end
    end
    if (vse) begin
      m_st = 1;
      m_y = 0;
      lbuf.delete();
      if (px) lbuf.push_back(col);
      if (DBUF && m_fin) m_bank = ~m_bank;
      m_fin = 0;
    end
    m_long  = (m_long && !clr) || sl;
    m_short = (m_short && !clr) || ss;
    m_extra = (m_extra && !clr) || sx;
    n.addr = m_addr;
    n.data = m_data;
    n.bank = m_bank;
    n.el   = m_long;
    n.es   = m_short;
    n.ex   = m_extra;
    @(posedge clk);
    #1;
    e = n;
  endtask

  task automatic idle(input int k);
    repeat (k) step(0, 0, 0, 2'd0, 0);
  endtask

  task automatic vsync();
    step(1, 0, 0, 2'd0, 0);
    step(0, 0, 0, 2'd0, 0);
  endtask

  task automatic hsync();
    step(0, 1, 0, 2'd0, 0);
    step(0, 0, 0, 2'd0, 0);
  endtask

  // pat < 0: colors 3,2,1,0 repeating; otherwise constant color pat
  task automatic pixels(input int k, input int pat);
    logic [1:0] c;
    for (int i = 0; i < k; i++) begin
      c = (pat < 0) ? 2'(3 - i % 4) : 2'(pat);
      step(0, 0, 1, c, 0);
    end
  endtask

  task automatic send_line(input int k, input int pat);
    pixels(k, pat);
    hsync();
  endtask

  task automatic do_reset();
    cmp_en = 1'b0;
    rst = 1'b0;
    bus.lcd_vsync = 0;
    bus.lcd_hsync = 0;
    bus.lcd_pixel = 0;
    bus.lcd_color = 0;
    bus.err_clr   = 0;
    mreset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    cmp_en = 1'b1;
  endtask

  initial begin
    do_reset();
    idle(2);
    chk("rst_fb_addr", 32'(bus.fb_addr), 32'h0);
    chk("rst_fb_data", 32'(bus.fb_data), 32'h0);
    chk("rst_fb_write", 32'(bus.fb_write), 32'h0);
    chk("rst_errs", 32'({bus.err_long, bus.err_short, bus.err_extra}), 32'h0);

    // line of 3,2,1,0 pattern
    ndone = 0;
    vsync();
    nwr = 0;
    send_line(H, -1);
    idle(1);
    chk("l0_writes", 32'(nwr), 32'd40);
    chk("l0_first_addr", 32'(first_addr), 32'd0);
    chk("l0_first_data", 32'(first_data), 32'hE4);
    chk("l0_last_addr", 32'(last_addr), 32'd39);
    chk("l0_last_data", 32'(last_data), 32'hE4);
    chk("l0_errs", 32'({bus.err_long, bus.err_short, bus.err_extra}), 32'h0);

    // rest of the frame
    for (int l = 1; l < V; l++) send_line(H, -1);
    idle(2);
    chk("frame_last_addr", 32'(last_addr), 32'h167F);
    chk("frame_done_cnt", 32'(ndone), 32'd1);
    chk("bank_pre_vsync", 32'(bus.fb_bank), 32'd0);

    // strobes in FRAME_END
    nwr = 0;
    pixels(5, 1);
    idle(2);
    chk("fe_writes", 32'(nwr), 32'd0);
    chk("fe_err_extra", 32'(bus.err_extra), 32'd1);
    vsync();
    idle(1);
    chk("bank_post_vsync", 32'(bus.fb_bank), 32'(DBUF));

    // over-long line, clear racing a set
    nwr = 0;
    pixels(H, 1);
    step(0, 0, 1, 2'd1, 1);
    step(0, 0, 1, 2'd1, 0);
    idle(1);
    chk("long_writes", 32'(nwr), 32'd40);
    chk("long_last_data", 32'(last_data), 32'h55);
    chk("long_err_long", 32'(bus.err_long), 32'd1);
    chk("long_extra_clr", 32'(bus.err_extra), 32'd0);
    hsync();
    step(0, 0, 0, 2'd0, 1);
    idle(1);
    chk("long_cleared", 32'(bus.err_long), 32'd0);

    // short line
    vsync();
    nwr = 0;
    send_line(H - 2, 3);
    idle(1);
    chk("short_writes", 32'(nwr), 32'd40);
    chk("short_last_addr", 32'(last_addr), 32'd39);
    chk("short_last_data", 32'(last_data), 32'hF0);
    chk("short_err", 32'(bus.err_short), 32'd1);
    nwr = 0;
    pixels(4, 2);
    idle(1);
    chk("short_next_addr", 32'(first_addr), 32'd40);
    chk("short_next_data", 32'(first_data), 32'hAA);

    // aborted frame
    ndone = 0;
    vsync();
    for (int l = 0; l < 50; l++) send_line(H, -1);
    pixels(6, 2);
    nwr = 0;
    vsync();
    idle(1);
    chk("abort_writes", 32'(nwr), 32'd0);
    chk("abort_done", 32'(ndone), 32'd0);
    pixels(4, 1);
    idle(1);
    chk("abort_next_addr", 32'(first_addr), 32'd0);
    chk("abort_next_data", 32'(first_data), 32'h55);
    chk("abort_bank", 32'(bus.fb_bank), 32'(DBUF));

    // asynchronous reset mid-byte
    pixels(2, 3);
    #2;
    cmp_en = 1'b0;
    rst = 1'b0;
    #1;
    chk("arst_outs", 32'({bus.fb_write, bus.frame_done, bus.fb_bank,
                          bus.err_long, bus.err_short, bus.err_extra}), 32'h0);
    chk("arst_addr", 32'(bus.fb_addr), 32'h0);
    chk("arst_data", 32'(bus.fb_data), 32'h0);
    do_reset();
    nwr = 0;
    pixels(4, 2);
    idle(2);
    chk("arst_no_write", 32'(nwr), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
